axi_ifetch_unit: RTL and testbench

- AXI4 read master that fetches 32-bit instructions from external memory for the IF stage of the pipelined core.
- Replaces the combinational instruction memory.
- Accepts one PC request at a time and issues a single-beat AR transaction.
- Returns the instruction with its PC through a valid/ready handshake; redirect flushes discard in-flight responses.

---
 rtl/axi_ifetch_unit.sv | 120 ++++++++++++
 tb/tb_axi_ifetch_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/axi_ifetch_unit.sv
// rtl/axi_ifetch_unit.sv - AXI4 single-beat instruction fetch master for the IF stage
module axi_ifetch_unit #(
  parameter int          ADDR_W    = 32,
  parameter int          ID_W      = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pc_req_valid,
  input  logic [ADDR_W-1:0] pc_req_addr,
  output logic              pc_req_ready,
  input  logic              flush,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_data,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_err,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [ID_W-1:0]   m_axi_arid,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic [2:0]        m_axi_arprot,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast
);

  typedef enum logic [2:0] {IDLE, AR, R, HOLD, DRAIN} state_t;

  state_t            state, stateNext;
  logic [ADDR_W-1:0] pcReg;
  logic              flushPending;
  logic [31:0]       dataReg;
  logic [ADDR_W-1:0] instrPcReg;
  logic              errReg;
  logic              misaligned;
  logic              unusedRlast;

  assign unusedRlast = m_axi_rlast;
  assign misaligned  = (pc_req_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (pc_req_valid) stateNext = misaligned ? HOLD : AR;
      // A flush cannot retract ARVALID, so the redirect is honoured once the address is taken.
      AR:    if (m_axi_arready) stateNext = (flushPending || flush) ? DRAIN : R;
      R: begin
        if (flush)             stateNext = m_axi_rvalid ? IDLE : DRAIN;
        else if (m_axi_rvalid) stateNext = HOLD;
      end
      DRAIN: if (m_axi_rvalid) stateNext = IDLE;
      HOLD:  if (flush || instr_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcReg        <= '0;
      flushPending <= 1'b0;
      dataReg      <= '0;
      instrPcReg   <= '0;
      errReg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_req_valid) begin
            pcReg        <= pc_req_addr;
            flushPending <= 1'b0;
            if (misaligned) begin
              dataReg    <= NOP_INSTR;
              instrPcReg <= pc_req_addr;
              errReg     <= 1'b1;
            end
          end
        end
        AR: if (flush) flushPending <= 1'b1;
        R: begin
          if (m_axi_rvalid && !flush) begin
            dataReg    <= (m_axi_rresp != 2'b00) ? NOP_INSTR : m_axi_rdata;
            instrPcReg <= pcReg;
            errReg     <= (m_axi_rresp != 2'b00);
          end
        end
        HOLD: if (flush || instr_ready) errReg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign pc_req_ready  = (state == IDLE);
  assign instr_valid   = (state == HOLD);
  assign instr_data    = dataReg;
  assign instr_pc      = instrPcReg;
  assign instr_err     = errReg;

  assign m_axi_arvalid = (state == AR);
  assign m_axi_araddr  = pcReg;
  assign m_axi_arid    = '0;
  assign m_axi_arlen   = 8'd0;
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;
  assign m_axi_arprot  = 3'b100;
  assign m_axi_rready  = (state == R) || (state == DRAIN);

endmodule

// File: tb/tb_axi_ifetch_unit.sv
// tb/tb_axi_ifetch_unit.sv - scoreboard bench for axi_ifetch_unit
module tb_axi_ifetch_unit;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pc_req_valid;
  logic [31:0] pc_req_addr;
  logic        pc_req_ready;
  logic        flush;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_err;
  logic        m_axi_arvalid;
  logic        m_axi_arready;
  logic [31:0] m_axi_araddr;
  logic [3:0]  m_axi_arid;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_rvalid;
  logic        m_axi_rready;
  logic [31:0] m_axi_rdata;
  logic [1:0]  m_axi_rresp;
  logic        m_axi_rlast;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  exp_t expQ[$];
  int   applied = 0;
  int   errors  = 0;

  axi_ifetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .pc_req_valid(pc_req_valid), .pc_req_addr(pc_req_addr), .pc_req_ready(pc_req_ready),
    .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_err(instr_err),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arid(m_axi_arid), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arprot(m_axi_arprot),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    applied++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted instruction (handshake without flush) must match the queue head.
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready && !flush) begin
      if (expQ.size() == 0) begin
        check("unexpected_instr", instr_pc, 32'hFFFFFFFF);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("sb_data", instr_data, e.data);
        check("sb_pc", instr_pc, e.pc);
        check("sb_err", {31'd0, instr_err}, {31'd0, e.err});
      end
    end
  end

  task automatic fetch(input logic [31:0] addr, input logic [31:0] rdata, input logic [1:0] resp,
                       input logic [31:0] expData, input logic expErr, input int hold);
    expQ.push_back('{data: expData, pc: addr, err: expErr});
    @(posedge clk); #1 pc_req_valid = 1'b1; pc_req_addr = addr;
    @(negedge clk); check("req_ready_idle", {31'd0, pc_req_ready}, 32'd1);
    @(posedge clk); #1 pc_req_valid = 1'b0; m_axi_arready = 1'b1;
    @(negedge clk);
    check("arvalid", {31'd0, m_axi_arvalid}, 32'd1);
    check("araddr", m_axi_araddr, addr);
    check("arlen", {24'd0, m_axi_arlen}, 32'd0);
    check("arsize", {29'd0, m_axi_arsize}, 32'd2);
    check("arburst_prot_id", {23'd0, m_axi_arburst, m_axi_arprot, m_axi_arid}, {23'd0, 2'b01, 3'b100, 4'd0});
    @(posedge clk); #1 m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = rdata; m_axi_rresp = resp;
    @(negedge clk);
    check("rready", {31'd0, m_axi_rready}, 32'd1);
    check("no_valid_in_r", {31'd0, instr_valid}, 32'd0);
    @(posedge clk); #1 m_axi_rvalid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, instr_valid}, 32'd1);
      check("hold_data", instr_data, expData);
      check("hold_pc", instr_pc, addr);
      check("hold_req_ready", {31'd0, pc_req_ready}, 32'd0);
      @(posedge clk); #1;
    end
    instr_ready = 1'b1;
    @(negedge clk); check("instr_valid", {31'd0, instr_valid}, 32'd1);
    @(posedge clk); #1 instr_ready = 1'b0;
    @(negedge clk);
    check("valid_drop", {31'd0, instr_valid}, 32'd0);
    check("req_ready_back", {31'd0, pc_req_ready}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; pc_req_valid = 1'b0; pc_req_addr = '0; flush = 1'b0; instr_ready = 1'b0;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b1;
    #12;
    check("rst_outputs", {26'd0, m_axi_arvalid, m_axi_rready, instr_valid, instr_err, 1'b0, pc_req_ready},
          {26'd0, 6'b000001});
    check("rst_data_pc_addr", instr_data | instr_pc | m_axi_araddr, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Normal fetch, then backpressure for 5 cycles
    fetch(32'h100, 32'h00500093, 2'b00, 32'h00500093, 1'b0, 0);
    fetch(32'h104, 32'h00A00113, 2'b00, 32'h00A00113, 1'b0, 5);

    // Flush in AR with arready held off 3 cycles; the beat is drained silently
    @(posedge clk); #1 pc_req_valid = 1'b1; pc_req_addr = 32'h180;
    @(posedge clk); #1 pc_req_valid = 1'b0; flush = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ar_held", {31'd0, m_axi_arvalid}, 32'd1);
      check("ar_addr_held", m_axi_araddr, 32'h180);
      @(posedge clk); #1 flush = 1'b0; m_axi_arready = (i == 2);
    end
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'hDEADBEEF; instr_ready = 1'b1;
    @(negedge clk);
    check("drain_rready", {31'd0, m_axi_rready}, 32'd1);
    check("drain_no_valid", {31'd0, instr_valid}, 32'd0);
    @(posedge clk); #1 m_axi_rvalid = 1'b0;
    @(negedge clk);
    check("drain_idle", {30'd0, instr_valid, pc_req_ready}, 32'd1);
    @(posedge clk); #1 instr_ready = 1'b0;
    fetch(32'h200, 32'h00000297, 2'b00, 32'h00000297, 1'b0, 0);

    // Flush in R without rvalid -> DRAIN
    @(posedge clk); #1 pc_req_valid = 1'b1; pc_req_addr = 32'h240;
    @(posedge clk); #1 pc_req_valid = 1'b0; m_axi_arready = 1'b1;
    @(posedge clk); #1 m_axi_arready = 1'b0; flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk); check("r_flush_drain", {30'd0, m_axi_rready, pc_req_ready}, 32'd2);
    @(posedge clk); #1 m_axi_rvalid = 1'b1; m_axi_rdata = 32'h11111111;
    @(posedge clk); #1 m_axi_rvalid = 1'b0;
    @(negedge clk); check("r_flush_idle", {30'd0, instr_valid, pc_req_ready}, 32'd1);

    // Flush in HOLD together with instr_ready: word must be dropped
    @(posedge clk); #1 pc_req_valid = 1'b1; pc_req_addr = 32'h140;
    @(posedge clk); #1 pc_req_valid = 1'b0; m_axi_arready = 1'b1;
    @(posedge clk); #1 m_axi_arready = 1'b0; m_axi_rvalid = 1'b1; m_axi_rdata = 32'h22222222; m_axi_rresp = 2'b00;
    @(posedge clk); #1 m_axi_rvalid = 1'b0; instr_ready = 1'b1; flush = 1'b1;
    @(negedge clk); check("hold_flush_valid", {31'd0, instr_valid}, 32'd1);
    @(posedge clk); #1 instr_ready = 1'b0; flush = 1'b0;
    @(negedge clk); check("hold_flush_idle", {29'd0, instr_valid, instr_err, pc_req_ready}, 32'd1);

    // AXI error response
    fetch(32'h300, 32'h12345678, 2'b10, NOP, 1'b1, 0);

    // Misaligned request: no AR, HOLD next cycle with NOP
    expQ.push_back('{data: NOP, pc: 32'h102, err: 1'b1});
    @(posedge clk); #1 pc_req_valid = 1'b1; pc_req_addr = 32'h102;
    @(posedge clk); #1 pc_req_valid = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    check("misalign_no_ar", {31'd0, m_axi_arvalid}, 32'd0);
    check("misalign_valid", {31'd0, instr_valid}, 32'd1);
    @(posedge clk); #1 instr_ready = 1'b0;
    @(negedge clk); check("misalign_err_clr", {30'd0, instr_valid, instr_err}, 32'd0);

    // Async reset in R
    @(posedge clk); #1 pc_req_valid = 1'b1; pc_req_addr = 32'h400;
    @(posedge clk); #1 pc_req_valid = 1'b0; m_axi_arready = 1'b1;
    @(posedge clk); #1 m_axi_arready = 1'b0;
    @(negedge clk); check("pre_rst_in_r", {31'd0, m_axi_rready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ctrl", {28'd0, m_axi_arvalid, m_axi_rready, instr_valid, instr_err}, 32'd0);
    check("arst_data", instr_data, 32'd0);
    check("arst_pc", instr_pc, 32'd0);
    check("arst_araddr", m_axi_araddr, 32'd0);
    check("arst_req_ready", {31'd0, pc_req_ready}, 32'd1);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk); check("post_rst_idle", {31'd0, pc_req_ready}, 32'd1);
    fetch(32'h100, 32'h00500093, 2'b00, 32'h00500093, 1'b0, 0);

    repeat (2) @(posedge clk);
    check("queue_empty", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end

endmodule
